btn_conditioner: RTL and testbench

- Upstream input stage for the hex counter/display top level.
- Takes the raw, bouncy, active-low on-board buttons and synchronises each one into the clk domain.
- Debounces each button against a slow sample tick.
- Delivers clean active-high levels, single-cycle press/release strobes and a per-button toggle. The top level uses these as RESET, HOLD and run/stop controls instead of the raw BTN pins.

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_debounce_ch.sv | 72 +++++++
 rtl/btn_conditioner.sv | 38 +++
 tb/tb_btn_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button conditioning block.
package btn_pkg;

  localparam int unsigned STABLE_TICKS_DEF = 5;
  localparam int unsigned CNT_W_DEF        = 4;
  localparam bit          ACTIVE_LOW_DEF   = 1'b1;

  // Board timebase: one sample_tick every 2**TICK_DIV_LOG2 clk
  localparam int unsigned TICK_DIV_LOG2    = 11;

  // Pin level of an idle (released) button for a given polarity
  function automatic logic released_lvl(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  localparam logic RELEASED_LVL = released_lvl(ACTIVE_LOW_DEF);

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level, registered press/release strobes and press toggle.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic toggle
);

  localparam logic             SYNC_RST = released_lvl(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             fire_c;
  logic             p_c;

  // Normalised synchronised sample, 1 = pressed
  assign p_c = sync2 ^ ACTIVE_LOW;

  // Debounce rules: matching level clears the count, last tick commits
  always_comb begin
    cnt_nxt_c = cnt;
    fire_c    = 1'b0;
    if (p_c == level) begin
      cnt_nxt_c = '0;
    end else if (sample_tick && (cnt == CNT_LAST)) begin
      cnt_nxt_c = '0;
      fire_c    = 1'b1;
    end else if (sample_tick) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  // Synchroniser, counter, level, strobes and toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= SYNC_RST;
      sync2  <= SYNC_RST;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rls    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      cnt    <= cnt_nxt_c;
      press  <= fire_c & p_c;
      rls    <= fire_c & ~p_c;
      if (fire_c) begin
        level <= p_c;
      end
      if (fire_c && p_c) begin
        toggle <= ~toggle;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NBTN raw bouncy buttons into clean levels, strobes and toggles.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NBTN         = 2,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_toggle
);

  // One independent debounce channel per button
  for (genvar i = 0; i < int'(NBTN); i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_W        (CNT_W),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .raw         (btn_raw[i]),
      .level       (btn_level[i]),
      .press       (btn_press[i]),
      .rls         (btn_release[i]),
      .toggle      (btn_toggle[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: NBTN=2, STABLE_TICKS=4, active-low,
// sample_tick every 8 clk.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_toggle;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;
  int press_cnt0 = 0;
  logic [1:0] press_seen;
  logic [7:0] any_seen;

  btn_conditioner #(
    .NBTN         (2),
    .STABLE_TICKS (4),
    .CNT_W        (4),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_toggle  (btn_toggle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample outputs 1 ns after the edge, schedule the tick
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample_tick = ((cyc % 8) == 7);
    press_seen = press_seen | btn_press;
    any_seen   = any_seen | {btn_level, btn_press, btn_release, btn_toggle};
    press_cnt0 = press_cnt0 + int'(btn_press[0]);
  endtask

  // Move to a cycle where the next tick is exactly 8 edges away
  task automatic align();
    while ((cyc % 8) != 0) step();
  endtask

  // Step until btn_level[idx] reaches val, bounded
  task automatic wait_level(input int idx, input logic val, output int cnt);
    cnt = 0;
    while (btn_level[idx] !== val && cnt < 400) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    btn_raw     = 2'b11;
    press_seen  = '0;
    any_seen    = '0;

    // 1: reset, then quiet for 200 clk
    repeat (4) step();
    reset = 1'b0;
    check("rst_level",   32'(btn_level),   32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_toggle",  32'(btn_toggle),  32'h0);
    any_seen = '0;
    repeat (200) step();
    check("idle_quiet", 32'(any_seen), 32'h0);

    // 2: press ch0; level rises 32 edges after the raw change
    align();
    btn_raw[0] = 1'b0;
    repeat (31) step();
    check("p0_before", 32'(btn_level), 32'h0);
    step();
    check("p0_level",  32'(btn_level),  32'h1);
    check("p0_press",  32'(btn_press),  32'h1);
    check("p0_toggle", 32'(btn_toggle), 32'h1);
    step();
    check("p0_press_end", 32'(btn_press),  32'h0);
    check("p0_toggle_hold", 32'(btn_toggle), 32'h1);

    // 3: ch1 bounces low for 3 ticks, high for 2, five times
    align();
    press_seen = '0;
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = 1'b0;
      repeat (24) step();
      btn_raw[1] = 1'b1;
      repeat (16) step();
    end
    repeat (40) step();
    check("b1_level",  32'(btn_level[1]),  32'h0);
    check("b1_press",  32'(press_seen[1]), 32'h0);
    check("b1_toggle", 32'(btn_toggle[1]), 32'h0);

    // 4: release ch0 after 100 clk, then a second press/release
    repeat (100) step();
    align();
    btn_raw[0] = 1'b1;
    repeat (31) step();
    check("r0_before", 32'(btn_level[0]), 32'h1);
    step();
    check("r0_level",   32'(btn_level),   32'h0);
    check("r0_release", 32'(btn_release), 32'h1);
    check("r0_press",   32'(btn_press),   32'h0);
    check("r0_toggle",  32'(btn_toggle),  32'h1);
    step();
    check("r0_release_end", 32'(btn_release), 32'h0);
    align();
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b1, n);
    check("p0b_latency", 32'(n), 32'd32);
    check("p0b_toggle", 32'(btn_toggle), 32'h0);
    align();
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b0, n);
    check("r0b_latency", 32'(n), 32'd32);
    check("r0b_toggle", 32'(btn_toggle), 32'h0);

    // 5: both channels pressed together
    align();
    btn_raw = 2'b00;
    wait_level(0, 1'b1, n);
    check("pb_latency", 32'(n), 32'd32);
    check("pb_press",   32'(btn_press), 32'h3);
    check("pb_level",   32'(btn_level), 32'h3);
    step();
    check("pb_press_end", 32'(btn_press), 32'h0);
    align();
    btn_raw = 2'b11;
    wait_level(0, 1'b0, n);
    check("rb_release", 32'(btn_release), 32'h3);
    check("rb_toggle",  32'(btn_toggle),  32'h3);
    repeat (10) step();

    // 6: reset during the third tick of a pending press, button held
    align();
    btn_raw[0] = 1'b0;
    repeat (23) step();
    reset = 1'b1;
    press_cnt0 = 0;
    repeat (10) step();
    check("rm_press",  32'(press_cnt0), 32'h0);
    check("rm_level",  32'(btn_level),  32'h0);
    check("rm_toggle", 32'(btn_toggle), 32'h0);
    align();
    reset = 1'b0;
    wait_level(0, 1'b1, n);
    check("rm_latency", 32'(n), 32'd32);
    repeat (60) step();
    check("rm_one_press", 32'(press_cnt0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
